// File: rtl/serial_compare_seq.sv
// Bit-serial magnitude comparator: walks operands MSB to LSB through one greater/less cell,
// with valid/ready handshakes on both the operand and result sides.
module serial_compare_seq #(
  parameter int W          = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic                 tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq,
  output logic [$clog2(W):0]   cycles
);

  localparam int IW = $clog2(W);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   a_q, b_q;
  logic           tc_q;
  logic           g_q, l_q;
  logic [IW-1:0]  idx_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q, out_valid_q;
  logic           gt_q, lt_q, eq_q;
  logic [CW-1:0]  cycles_q;

  logic           abit, bbit;
  logic           g_d, l_d;
  logic [CW-1:0]  cnt_d;
  logic           finish;

  // The sign bit is inverted for signed compares so the unsigned cell orders two's-complement values.
  always_comb begin
    abit   = a_q[idx_q] ^ ((idx_q == MSB_IDX) & tc_q);
    bbit   = b_q[idx_q] ^ ((idx_q == MSB_IDX) & tc_q);
    g_d    = g_q | (~l_q & abit & ~bbit);
    l_d    = l_q | (~g_q & ~abit & bbit);
    cnt_d  = cnt_q + 1'b1;
    finish = (EARLY_EXIT && (g_d || l_d)) || (idx_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tc_q        <= 1'b0;
      g_q         <= 1'b0;
      l_q         <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      cycles_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            tc_q       <= tc;
            g_q        <= 1'b0;
            l_q        <= 1'b0;
            idx_q      <= MSB_IDX;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          g_q   <= g_d;
          l_q   <= l_d;
          cnt_q <= cnt_d;
          if (finish) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            gt_q        <= g_d;
            lt_q        <= l_d;
            eq_q        <= ~g_d & ~l_d;
            cycles_q    <= cnt_d;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign cycles    = cycles_q;

endmodule
